// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - per-pin input conditioning: 2-flop sync, debounce, edge detect, sticky irq
// Feeds gpio's input data register (stable_o) and its interrupt line (irq_o).
module gpio_in_cond #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] set_w;

  // The count only runs while the synced level disagrees with stable; any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign rise_o = stable_q & ~prev_q;
  assign fall_o = ~stable_q & prev_q;
  assign set_w  = (rise_o & rise_en_i) | (fall_o & fall_en_i);

  // A new edge outranks a clear landing in the same cycle.
  assign pending_d = (pending_q & ~irq_clr_i) | set_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= pin_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      prev_q    <= stable_q;
      pending_q <= pending_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable_o  = stable_q;
  assign pending_o = pending_q;
  assign irq_o     = |pending_q;

endmodule
